// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared state encoding, status codes and length check for the SPI sequencer
package spi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        RESPOND,
        GAP
    } state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BAD_LEN = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
        return (len != 0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/spi_seq_down_counter.sv
// rtl/spi_seq_down_counter.sv - loadable down-counter that stops at zero and flags it
module spi_seq_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/spi_transaction_sequencer.sv
// rtl/spi_transaction_sequencer.sv - one-at-a-time SPI command launcher; SPI_SEQ_TIMEOUT_EN adds a done watchdog
import spi_seq_pkg::*;

module spi_transaction_sequencer #(
    parameter int DATA_WIDTH            = 32,
    parameter int TRANSACTION_LEN_WIDTH = 8,
    parameter int GAP_WIDTH             = 8,
    parameter int TIMEOUT_CYCLES        = 4096
) (
    input  logic                             fabric_clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [TRANSACTION_LEN_WIDTH-1:0] cmd_length,
    input  logic [DATA_WIDTH-1:0]            cmd_data,
    input  logic [DATA_WIDTH-1:0]            cmd_rw_mask,
    input  logic [GAP_WIDTH-1:0]             cfg_gap_cycles,
    output logic                             spi_start,
    output logic [TRANSACTION_LEN_WIDTH-1:0] spi_transaction_length,
    output logic [DATA_WIDTH-1:0]            spi_transaction_data,
    output logic [DATA_WIDTH-1:0]            spi_transaction_rw_mask,
    input  logic                             spi_done,
    input  logic [DATA_WIDTH-1:0]            spi_read_data,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_read_data,
    output logic [1:0]                       rsp_status,
    output logic [15:0]                      txn_count
);

    state_t state;

    logic rsp_fire;
    logic gap_load;
    logic gap_zero;
    logic wd_expired;

    assign rsp_fire = (state == RESPOND) && rsp_valid && rsp_ready;
    assign gap_load = rsp_fire && (cfg_gap_cycles != '0);

    // Loaded with gap-1 so the zero flag lands on the last GAP cycle.
    spi_seq_down_counter #(
        .WIDTH(GAP_WIDTH)
    ) u_gap_counter (
        .clk       (fabric_clk),
        .reset     (reset),
        .load      (gap_load),
        .load_value(cfg_gap_cycles - GAP_WIDTH'(1)),
        .dec       (state == GAP),
        .zero      (gap_zero)
    );

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic wd_zero;

    spi_seq_down_counter #(
        .WIDTH(WD_WIDTH)
    ) u_watchdog (
        .clk       (fabric_clk),
        .reset     (reset),
        .load      (state == LAUNCH),
        .load_value(WD_WIDTH'(TIMEOUT_CYCLES - 1)),
        .dec       (state == WAIT_DONE),
        .zero      (wd_zero)
    );

    assign wd_expired = (state == WAIT_DONE) && wd_zero;
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge fabric_clk) begin
        if (reset) begin
            state                   <= IDLE;
            cmd_ready               <= 1'b1;
            spi_start               <= 1'b0;
            spi_transaction_length  <= '0;
            spi_transaction_data    <= '0;
            spi_transaction_rw_mask <= '0;
            rsp_valid               <= 1'b0;
            rsp_read_data           <= '0;
            rsp_status              <= ST_OK;
            txn_count               <= '0;
        end else begin
            spi_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        spi_transaction_length  <= cmd_length;
                        spi_transaction_data    <= cmd_data;
                        spi_transaction_rw_mask <= cmd_rw_mask;
                        cmd_ready               <= 1'b0;
                        if (len_ok(32'(cmd_length), DATA_WIDTH)) begin
                            spi_start <= 1'b1;
                            state     <= LAUNCH;
                        end else begin
                            rsp_valid     <= 1'b1;
                            rsp_status    <= ST_BAD_LEN;
                            rsp_read_data <= '0;
                            state         <= RESPOND;
                        end
                    end
                end
                LAUNCH: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A done pulse on the expiry cycle still counts as success.
                    if (spi_done) begin
                        rsp_read_data <= spi_read_data & ~spi_transaction_rw_mask;
                        rsp_status    <= ST_OK;
                        rsp_valid     <= 1'b1;
                        state         <= RESPOND;
                    end else if (wd_expired) begin
                        rsp_read_data <= '0;
                        rsp_status    <= ST_TIMEOUT;
                        rsp_valid     <= 1'b1;
                        state         <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + 16'd1;
                        if (cfg_gap_cycles != '0) begin
                            state <= GAP;
                        end else begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_zero) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
